// File: rtl/shift_pipe_ctrl.sv
// Two-stage shift/rotate execution unit: stage 1 captures the request, stage 2
// computes and registers the result and zero flag, valid/ready on both sides.
module shift_pipe_ctrl #(
    parameter int unsigned N = 16,
    parameter int unsigned C = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [1:0]   in_op,
    input  logic [N-1:0] in_data,
    input  logic [C-1:0] in_cnt,
    input  logic         flush,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] out_data,
    output logic         out_zero
);

    typedef enum logic [1:0] {
        OP_ROL = 2'b00,
        OP_SLL = 2'b01,
        OP_ROR = 2'b10,
        OP_SRL = 2'b11
    } op_e;

    logic         s1_valid;
    op_e          s1_op;
    logic [N-1:0] s1_data;
    logic [C-1:0] s1_cnt;

    logic         s2_adv;
    logic         s1_adv;
    logic [C-1:0] wrap_cnt;
    logic [N-1:0] r_fwd;
    logic [N-1:0] r_wrap;
    logic [N-1:0] l_fwd;
    logic [N-1:0] l_wrap;
    logic [N-1:0] result;

    // Logarithmic right-shift network: one conditional stage per count bit.
    function automatic logic [N-1:0] rsh(input logic [N-1:0] x, input logic [C-1:0] k);
        logic [N-1:0] v;
        v = x;
        for (int unsigned i = 0; i < C; i++) begin
            if (k[i]) v = v >> (32'd1 << i);
        end
        return v;
    endfunction

    function automatic logic [N-1:0] rev(input logic [N-1:0] x);
        logic [N-1:0] r;
        r = '0;
        for (int unsigned i = 0; i < N; i++) begin
            r[i] = x[N-1-i];
        end
        return r;
    endfunction

    assign s2_adv    = !out_valid || out_ready;
    assign s1_adv    = !s1_valid || s2_adv;
    assign in_ready  = rst_n && s1_adv && !flush;

    // Result datapath; left shifts reuse the right network on bit-reversed data.
    always_comb begin
        result   = '0;
        // N - cnt modulo N; cnt = 0 makes the wrap term equal the operand itself.
        wrap_cnt = C'(0) - s1_cnt;
        r_fwd    = rsh(s1_data, s1_cnt);
        r_wrap   = rsh(s1_data, wrap_cnt);
        l_fwd    = rev(rsh(rev(s1_data), s1_cnt));
        l_wrap   = rev(rsh(rev(s1_data), wrap_cnt));
        case (s1_op)
            OP_SRL:  result = r_fwd;
            OP_ROR:  result = r_fwd | l_wrap;
            OP_SLL:  result = l_fwd;
            OP_ROL:  result = l_fwd | r_wrap;
            default: result = '0;
        endcase
    end

    // Stage 1: operand capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_op    <= OP_ROL;
            s1_data  <= '0;
            s1_cnt   <= '0;
        end else if (flush) begin
            s1_valid <= 1'b0;
        end else if (s1_adv) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_op   <= op_e'(in_op);
                s1_data <= in_data;
                s1_cnt  <= in_cnt;
            end
        end
    end

    // Stage 2: result register, held while the consumer stalls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_zero  <= 1'b0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (s2_adv) begin
            out_valid <= s1_valid;
            out_data  <= result;
            out_zero  <= (result == '0);
        end
    end

endmodule

// File: tb/tb_shift_pipe_ctrl.sv
// Self-checking bench for shift_pipe_ctrl: directed literal cases plus a
// randomized run compared every cycle against a two-slot behavioural model.
module tb_shift_pipe_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [1:0]  in_op = 2'd0;
    logic [15:0] in_data = 16'd0;
    logic [3:0]  in_cnt = 4'd0;
    logic        flush = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] out_data;
    logic        out_zero;

    int n_checks = 0;
    int n_fail = 0;

    // Model: occupancy and precomputed result of each pipeline slot.
    bit          m1_v = 1'b0;
    bit          m2_v = 1'b0;
    logic [15:0] m1_res = 16'd0;
    logic [15:0] m2_res = 16'd0;
    bit          last_rdy;

    always #5 clk = ~clk;

    shift_pipe_ctrl #(.N(16), .C(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_op(in_op), .in_data(in_data), .in_cnt(in_cnt),
        .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_zero(out_zero)
    );

    function automatic logic [15:0] ref_shift(input logic [1:0] op, input logic [15:0] d,
                                              input logic [3:0] c);
        logic [31:0] dd;
        dd = {d, d};
        case (op)
            2'd0: begin dd = dd << c; return dd[31:16]; end
            2'd1: return d << c;
            2'd2: begin dd = dd >> c; return dd[15:0]; end
            default: return d >> c;
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // One clock cycle, entered and left at a falling edge.
    task automatic cyc(input bit iv, input logic [1:0] op, input logic [15:0] d,
                       input logic [3:0] c, input bit fl, input bit ordy);
        bit s2adv, s1adv, erdy;
        in_valid  = iv;
        in_op     = op;
        in_data   = d;
        in_cnt    = c;
        flush     = fl;
        out_ready = ordy;
        #1;
        s2adv = !m2_v || ordy;
        s1adv = !m1_v || s2adv;
        erdy  = rst_n && s1adv && !fl;
        last_rdy = in_ready;
        check("in_ready", 32'(in_ready), 32'(erdy));
        @(posedge clk);
        if (rst_n) begin
            if (fl) begin
                m1_v = 1'b0;
                m2_v = 1'b0;
            end else begin
                if (s2adv) begin
                    m2_v = m1_v;
                    if (m1_v) m2_res = m1_res;
                end
                if (s1adv) begin
                    m1_v = iv;
                    if (iv) m1_res = ref_shift(op, d, c);
                end
            end
        end
        @(negedge clk);
        check("out_valid", 32'(out_valid), 32'(m2_v));
        if (m2_v) begin
            check("out_data", 32'(out_data), 32'(m2_res));
            check("out_zero", 32'(out_zero), 32'(m2_res == 16'd0));
        end
    endtask

    task automatic idle(input bit ordy);
        cyc(1'b0, 2'd0, 16'd0, 4'd0, 1'b0, ordy);
    endtask

    // Asynchronous reset asserted between edges; outputs must clear at once.
    task automatic mid_reset();
        #2;
        rst_n = 1'b0;
        #1;
        check("rst out_valid", 32'(out_valid), 32'd0);
        check("rst out_data", 32'(out_data), 32'd0);
        check("rst out_zero", 32'(out_zero), 32'd0);
        check("rst in_ready", 32'(in_ready), 32'd0);
        m1_v = 1'b0;
        m2_v = 1'b0;
        @(negedge clk);
        idle(1'b1);
        rst_n = 1'b1;
    endtask

    initial begin
        repeat (2) @(negedge clk);
        check("reset out_valid", 32'(out_valid), 32'd0);
        check("reset out_data", 32'(out_data), 32'd0);
        check("reset out_zero", 32'(out_zero), 32'd0);
        check("reset in_ready", 32'(in_ready), 32'd0);
        rst_n = 1'b1;

        // Single SRL, latency two edges.
        cyc(1'b1, 2'd3, 16'h8001, 4'd1, 1'b0, 1'b1);
        idle(1'b1);
        check("lat out_valid", 32'(out_valid), 32'd1);
        check("lat out_data", 32'(out_data), 32'h4000);
        check("lat out_zero", 32'(out_zero), 32'd0);
        idle(1'b1);

        // Back-to-back mixed operations, one result per cycle.
        cyc(1'b1, 2'd2, 16'h8001, 4'd4, 1'b0, 1'b1);
        cyc(1'b1, 2'd0, 16'h8001, 4'd4, 1'b0, 1'b1);
        check("b2b ror", 32'(out_data), 32'h1800);
        cyc(1'b1, 2'd1, 16'hFFFF, 4'd15, 1'b0, 1'b1);
        check("b2b rol", 32'(out_data), 32'h0018);
        cyc(1'b1, 2'd3, 16'h0001, 4'd1, 1'b0, 1'b1);
        check("b2b sll", 32'(out_data), 32'h8000);
        idle(1'b1);
        check("b2b srl", 32'(out_data), 32'h0000);
        check("b2b zero", 32'(out_zero), 32'd1);
        idle(1'b1);

        // Backpressure: two accepted, third stalls, then drain in order.
        cyc(1'b1, 2'd1, 16'h0003, 4'd2, 1'b0, 1'b0);
        cyc(1'b1, 2'd3, 16'hF000, 4'd4, 1'b0, 1'b0);
        check("bp first", 32'(out_data), 32'h000C);
        cyc(1'b1, 2'd0, 16'h1234, 4'd8, 1'b0, 1'b0);
        check("bp stall rdy", 32'(last_rdy), 32'd0);
        check("bp hold", 32'(out_data), 32'h000C);
        cyc(1'b1, 2'd0, 16'h1234, 4'd8, 1'b0, 1'b1);
        check("bp resume rdy", 32'(last_rdy), 32'd1);
        check("bp second", 32'(out_data), 32'h0F00);
        idle(1'b1);
        check("bp third", 32'(out_data), 32'h3412);
        idle(1'b1);
        check("bp empty", 32'(out_valid), 32'd0);

        // Zero count is the identity for every op.
        for (int op = 0; op < 4; op++) begin
            cyc(1'b1, 2'(op), 16'hA5C3, 4'd0, 1'b0, 1'b1);
            if (op > 0) check("cnt0", 32'(out_data), 32'hA5C3);
        end
        idle(1'b1);
        check("cnt0 last", 32'(out_data), 32'hA5C3);
        idle(1'b1);

        // Flush with both stages full and the consumer stalled.
        cyc(1'b1, 2'd3, 16'h00F0, 4'd4, 1'b0, 1'b0);
        cyc(1'b1, 2'd1, 16'h000F, 4'd4, 1'b0, 1'b0);
        cyc(1'b1, 2'd0, 16'h1111, 4'd1, 1'b1, 1'b0);
        check("flush rdy", 32'(last_rdy), 32'd0);
        check("flush out_valid", 32'(out_valid), 32'd0);
        cyc(1'b1, 2'd3, 16'h0100, 4'd8, 1'b0, 1'b1);
        idle(1'b1);
        check("post flush valid", 32'(out_valid), 32'd1);
        check("post flush data", 32'(out_data), 32'h0001);
        idle(1'b1);
        check("post flush empty", 32'(out_valid), 32'd0);

        // Reset mid-stream drops everything in flight.
        cyc(1'b1, 2'd1, 16'h00FF, 4'd4, 1'b0, 1'b0);
        cyc(1'b1, 2'd2, 16'h00FF, 4'd4, 1'b0, 1'b0);
        mid_reset();
        cyc(1'b1, 2'd1, 16'h0001, 4'd3, 1'b0, 1'b1);
        idle(1'b1);
        check("post reset data", 32'(out_data), 32'h0008);
        idle(1'b1);
        check("post reset empty", 32'(out_valid), 32'd0);

        // Randomized traffic with flushes and backpressure.
        for (int i = 0; i < 3000; i++) begin
            logic [15:0] d;
            d = ($urandom_range(0, 7) == 0) ? 16'd0 : 16'($urandom);
            cyc($urandom_range(0, 3) != 0, 2'($urandom), d, 4'($urandom),
                $urandom_range(0, 19) == 0, $urandom_range(0, 3) != 0);
            if (i == 1500) mid_reset();
        end
        repeat (3) idle(1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/shift_pipe_ctrl.md
Name: shift_pipe_ctrl

Overview:
- Two-stage pipelined shift/rotate execution unit for the 16-bit datapath.
- Accepts one shift request per cycle from issue over a valid/ready handshake.
- Stage 1 registers the operands and decodes the operation; stage 2 computes the result and registers it.
- Delivers the result with a zero flag to writeback over a second valid/ready handshake.
- Sits between the decode/issue stage and the writeback mux, and drives the logical right-shift datapath.

Parameters:
- N, 16, data width in bits.
- C, 4, shift-count width; equals log2(N).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  request valid.
- in_ready  output  1  unit can accept a request this cycle.
- in_op  input  2  00 ROL, 01 SLL, 10 ROR, 11 SRL.
- in_data  input  N  operand to shift.
- in_cnt  input  C  shift amount, 0..N-1.
- flush  input  1  synchronous pipeline kill (branch mispredict/exception).
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts result.
- out_data  output  N  shift/rotate result.
- out_zero  output  1  high when out_data == 0; qualified by out_valid.

Behaviour:
- Reset (rst_n low, asynchronous): s1_valid=0, s2_valid=0, out_valid=0, out_data=0, out_zero=0, in_ready=0 while reset is asserted. All stage-1 operand registers clear to 0. Normal operation starts on the first edge after rst_n rises.
- Transfer rules:
  - Input transfer occurs when in_valid && in_ready at a rising edge.
  - Output transfer occurs when out_valid && out_ready at a rising edge.
- Advance conditions:
  - s2_adv = !s2_valid || out_ready.
  - s1_adv = !s1_valid || s2_adv.
  - in_ready = s1_adv && !flush. This is combinational; no combinational path from in_valid to in_ready.
- Stage 1: on input transfer, capture op, data and cnt, and set s1_valid. If s1_adv holds and there is no input transfer, s1_valid clears.
- Stage 2: on s2_adv, load the result computed from the stage-1 registers, load zero = (result==0), and set s2_valid=s1_valid.
- Hold under backpressure: while s2_valid && !out_ready, out_data/out_zero hold stable and stage 1 holds. in_ready stays low only if stage 1 is also full.
- Latency: request accepted at edge k appears with out_valid high after edge k+1; it is consumable at edge k+2 at the earliest.
- Throughput: one result per cycle while out_ready is held high.
- Arithmetic, with cnt taken as unsigned:
  - SRL: zero-fill from MSB.
  - SLL: zero-fill from LSB.
  - ROR / ROL: bits wrap around.
  - cnt=0: out_data = in_data for all ops.
  - No sign extension, no carry out.
- Implementation constraint: SRL and ROR share the log-stage right-shift network (shift by 1,2,4,8 selected by cnt bits 0..3). ROR ORs in the left-shifted-by-(N-cnt) term. Left ops use a mirrored network.
- Flush:
  - At an edge with flush=1, s1_valid and s2_valid clear regardless of handshakes, and out_valid drops the next cycle.
  - Any request presented in the flush cycle is not accepted (in_ready=0).
  - out_data retains its last value (don't-care while out_valid=0).
- Simultaneous flush and out_ready: the output transfer in that cycle still completes (the consumer sees it), then the pipe is empty.
- Reset mid-operation: all in-flight requests are dropped with no output produced.
- Out-of-range behaviour: none; cnt width C bounds all shifts to N-1.

Test Plan:
- Single SRL in_data=0x8001 cnt=1, out_ready=1 -> out_valid after edge 2, out_data=0x4000, out_zero=0.
- Back-to-back ROR 0x8001 cnt=4, ROL 0x8001 cnt=4, SLL 0xFFFF cnt=15, SRL 0x0001 cnt=1 -> consecutive out_data 0x1800, 0x0018, 0x8000, 0x0000 (last with out_zero=1), one per cycle.
- Backpressure: out_ready=0 with 3 requests offered -> first two accepted, then in_ready=0; out_data holds 1st result stable. Raising out_ready drains all 3 in order with none lost or duplicated.
- cnt=0 for each op with in_data=0xA5C3 -> out_data=0xA5C3 four times.
- Flush with both stages full and out_ready=0 -> out_valid=0 next cycle, in_ready=0 during flush; next request after flush produces only its own result.
- Assert rst_n=0 asynchronously mid-stream (between edges) -> out_valid, out_data, out_zero go 0 immediately; after release the pipe is empty and accepts new requests.
